// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RISC-V pipeline: execute-stage operand
// forwarding, load-use / branch / memory-wait stall and flush generation,
// a memory-wait FSM with timeout, and saturating performance counters.
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32,
    parameter int MEM_TIMEOUT    = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
    input  logic [REG_ADDR_WIDTH-1:0] RdE,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    input  logic [REG_ADDR_WIDTH-1:0] RdW,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic                      LoadE,
    input  logic                      PCSrcE,
    input  logic                      MemReqM,
    input  logic                      MemReadyM,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      FlushW,
    output logic                      MemTimeout,
    output logic [CNT_WIDTH-1:0]      StallCount,
    output logic [CNT_WIDTH-1:0]      FlushCount
);

    localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [REG_ADDR_WIDTH-1:0] X0 = '0;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_state_t;

    mem_state_t          state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q;
    logic                mem_wait;
    logic                timeout_fire;
    logic                mem_stall;
    logic                lw_stall;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Forward select: M-stage result wins over W-stage; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs);
        if (RegWriteM && (RdM != X0) && (RdM == rs))
            return 2'b10;
        else if (RegWriteW && (RdW != X0) && (RdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Hazard detection and forwarding selects.
    always_comb begin
        ForwardAE    = fwd_sel(Rs1E);
        ForwardBE    = fwd_sel(Rs2E);
        lw_stall     = LoadE && (RdE != X0) && ((RdE == Rs1D) || (RdE == Rs2D));
        mem_wait     = MemReqM && !MemReadyM;
        timeout_fire = (state_q == WAIT) && mem_wait && (wcnt_q == WLAST);
        mem_stall    = mem_wait && !timeout_fire;
    end

    // Memory-wait FSM next state; leaves WAIT on completion, dropped request or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (mem_wait) state_d = WAIT;
            WAIT: if (!mem_wait || timeout_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stall/flush priority: memory wait, then taken branch, then load-use.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // FSM state, wait counter (cleared on entry to WAIT) and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            MemTimeout <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE)
                wcnt_q <= '0;
            else
                wcnt_q <= wcnt_q + WCNT_W'(1);
            if (timeout_fire)
                MemTimeout <= 1'b1;
        end
    end

    // Saturating performance counters for front-end stalls and E-stage flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (StallF) StallCount <= sat_inc(StallCount);
            if (FlushE) FlushCount <= sat_inc(FlushCount);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (small counters and short timeout).
module tb_hazard_ctrl;

    localparam int RW = 5;
    localparam int CW = 4;
    localparam int TO = 4;

    logic          clk;
    logic          rst_n;
    logic [RW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic          MemTimeout;
    logic [CW-1:0] StallCount, FlushCount;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemTimeout(MemTimeout), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; LoadE = 1'b0;
        PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        #12;
        chk("rst_stallcnt", 32'(StallCount), 32'd0);
        chk("rst_flushcnt", 32'(FlushCount), 32'd0);
        chk("rst_timeout", 32'(MemTimeout), 32'd0);
        chk("rst_stallf", 32'(StallF), 32'd0);
        tick();
        rst_n = 1'b1;

        // forwarding
        Rs1E = 5; RdM = 5; RdW = 5; RegWriteM = 1'b1; RegWriteW = 1'b1; #1;
        chk("fwdA_M", 32'(ForwardAE), 32'd2);
        chk("fwdB_none", 32'(ForwardBE), 32'd0);
        RegWriteM = 1'b0; #1;
        chk("fwdA_W", 32'(ForwardAE), 32'd1);
        RdM = 0; RdW = 0; Rs1E = 0; RegWriteM = 1'b1; #1;
        chk("fwdA_x0", 32'(ForwardAE), 32'd0);
        RdM = 9; Rs2E = 9; RdW = 9; #1;
        chk("fwdB_M", 32'(ForwardBE), 32'd2);
        RdM = 3; #1;
        chk("fwdB_W", 32'(ForwardBE), 32'd1);
        clr();

        // load-use
        LoadE = 1'b1; RdE = 7; Rs2D = 7; Rs1D = 3; #1;
        chk("lw_stallf", 32'(StallF), 32'd1);
        chk("lw_stalld", 32'(StallD), 32'd1);
        chk("lw_flushe", 32'(FlushE), 32'd1);
        chk("lw_stalle", 32'(StallE), 32'd0);
        chk("lw_flushd", 32'(FlushD), 32'd0);
        tick();
        chk("lw_scnt1", 32'(StallCount), 32'd1);
        chk("lw_fcnt1", 32'(FlushCount), 32'd1);
        tick();
        chk("lw_scnt2", 32'(StallCount), 32'd2);
        RdE = 0; #1;
        chk("lw_x0_stallf", 32'(StallF), 32'd0);
        chk("lw_x0_flushe", 32'(FlushE), 32'd0);
        tick();
        chk("lw_x0_scnt", 32'(StallCount), 32'd2);

        // branch supersedes load-use
        RdE = 7; PCSrcE = 1'b1; #1;
        chk("br_flushd", 32'(FlushD), 32'd1);
        chk("br_flushe", 32'(FlushE), 32'd1);
        chk("br_stallf", 32'(StallF), 32'd0);
        chk("br_stalld", 32'(StallD), 32'd0);
        tick();
        chk("br_fcnt", 32'(FlushCount), 32'd3);
        chk("br_scnt", 32'(StallCount), 32'd2);
        clr();

        // memory wait: 3 miss cycles then ready
        MemReqM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) PCSrcE = 1'b1;
            #1;
            chk("mw_stallf", 32'(StallF), 32'd1);
            chk("mw_stallm", 32'(StallM), 32'd1);
            chk("mw_flushw", 32'(FlushW), 32'd1);
            chk("mw_flushd", 32'(FlushD), 32'd0);
            tick();
            PCSrcE = 1'b0;
        end
        MemReadyM = 1'b1; #1;
        chk("mw_rel_stallf", 32'(StallF), 32'd0);
        chk("mw_rel_stallm", 32'(StallM), 32'd0);
        chk("mw_rel_flushw", 32'(FlushW), 32'd0);
        tick();
        chk("mw_scnt", 32'(StallCount), 32'd5);
        chk("mw_fcnt", 32'(FlushCount), 32'd3);
        clr();
        tick();

        // timeout
        MemReqM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_stalle", 32'(StallE), 32'd1);
            tick();
        end
        #1;
        chk("to_fire_stallf", 32'(StallF), 32'd0);
        chk("to_pre_flag", 32'(MemTimeout), 32'd0);
        tick();
        chk("to_flag", 32'(MemTimeout), 32'd1);
        chk("to_scnt", 32'(StallCount), 32'd9);
        clr(); #1;
        tick();
        chk("to_sticky", 32'(MemTimeout), 32'd1);
        chk("to_idle_stallf", 32'(StallF), 32'd0);

        // counter saturation
        LoadE = 1'b1; RdE = 7; Rs1D = 7;
        repeat (20) tick();
        chk("sat_scnt", 32'(StallCount), 32'd15);
        chk("sat_fcnt", 32'(FlushCount), 32'd15);
        chk("sat_sticky", 32'(MemTimeout), 32'd1);
        clr();

        // reset mid-WAIT
        MemReqM = 1'b1;
        tick();
        tick();
        rst_n = 1'b0; #1;
        chk("mr_scnt", 32'(StallCount), 32'd0);
        chk("mr_fcnt", 32'(FlushCount), 32'd0);
        chk("mr_timeout", 32'(MemTimeout), 32'd0);
        chk("mr_comb_stallf", 32'(StallF), 32'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mr_stallf", 32'(StallF), 32'd1);
            tick();
        end
        #1;
        chk("mr_fire_stallf", 32'(StallF), 32'd0);
        tick();
        chk("mr_to_flag", 32'(MemTimeout), 32'd1);
        chk("mr_scnt4", 32'(StallCount), 32'd4);
        clr();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard controller for the 5-stage RISC-V pipeline; directly upstream of the execute-stage forwarding muxes and drives their 2-bit Forward selects (00 = register-file value, 01 = ResultW, 10 = ALUResultM).
- Also generates per-stage stall/flush for load-use, taken branches and data-memory wait states.
- Holds a memory-wait FSM with timeout, plus saturating performance counters.

Parameters:
- REG_ADDR_WIDTH, 5, register index width.
- CNT_WIDTH, 32, width of performance counters.
- MEM_TIMEOUT, 64, max consecutive wait cycles before error (≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Rs1D, Rs2D  in  REG_ADDR_WIDTH  decode-stage source registers.
- Rs1E, Rs2E  in  REG_ADDR_WIDTH  execute-stage source registers.
- RdE, RdM, RdW  in  REG_ADDR_WIDTH  destination registers in E/M/W.
- RegWriteM, RegWriteW  in  1  writeback enables in M/W.
- LoadE  in  1  instruction in E is a load.
- PCSrcE  in  1  taken branch/jump resolved in E.
- MemReqM  in  1  M-stage load/store access valid.
- MemReadyM  in  1  data memory completes access this cycle.
- ForwardAE, ForwardBE  out  2  forward selects for operands A/B.
- StallF, StallD, StallE, StallM  out  1  hold stage register.
- FlushD, FlushE, FlushW  out  1  insert bubble into stage register.
- MemTimeout  out  1  sticky error flag.
- StallCount, FlushCount  out  CNT_WIDTH  performance counters.

Behaviour:
- Forwarding (combinational): ForwardAE = 10 if RegWriteM & RdM≠0 & RdM==Rs1E; else 01 if RegWriteW & RdW≠0 & RdW==Rs1E; else 00. ForwardBE uses Rs2E identically. M has priority over W. Register x0 is never forwarded. Encoding 11 is never produced.
- Load-use (combinational): lwStall = LoadE & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- Memory FSM: states IDLE, WAIT. memWait = MemReqM & !MemReadyM.
  - IDLE→WAIT when memWait.
  - WAIT→IDLE when MemReadyM.
  - WAIT→IDLE when wait counter reaches MEM_TIMEOUT-1; this also sets MemTimeout sticky, which clears only on reset.
  - Wait counter clears on entry to WAIT and counts cycles spent in WAIT.
- memStall = memWait (combinational; covers the first miss cycle from IDLE), gated off once the timeout fires that cycle.
- Output priority, highest first:
  1. memStall: StallF/D/E/M=1, FlushW=1 (bubble into W). Flush/lw logic is suppressed: FlushD=FlushE=0 and PCSrcE is held by the frozen E stage.
  2. PCSrcE: FlushD=1, FlushE=1, StallF=StallD=0. A branch supersedes a load-use stall in the same cycle.
  3. lwStall: StallF=StallD=1, FlushE=1.
  4. Otherwise all stall/flush outputs are 0.
- StallE and StallM are asserted only by memStall.
- Counters (registered):
  - StallCount increments on any cycle with StallF=1.
  - FlushCount increments on any cycle with FlushE=1.
  - Both saturate at all-ones and never wrap.
- Reset (async, rst_n=0): FSM=IDLE, wait counter=0, MemTimeout=0, StallCount=0, FlushCount=0.
  - Combinational outputs follow their equations with FSM in IDLE.
  - Reset asserted mid-WAIT returns immediately to IDLE. On release, stalls depend only on current inputs.

Test Plan:
- Forwarding priority: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 → ForwardAE=10. Drop RegWriteM → 01. Set RdM=RdW=0 with Rs1E=0 → 00.
- Load-use: LoadE=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1, StallCount +1 per cycle. With RdE=0 → no stall.
- Branch vs load-use: PCSrcE=1 and lwStall true together → FlushD=FlushE=1, StallF=StallD=0, FlushCount +1.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 → StallF..M=1 and FlushW=1 for exactly 3 cycles. FSM in WAIT 2 cycles. Outputs release the cycle MemReadyM=1.
- Timeout: MEM_TIMEOUT=4, MemReadyM held 0 → MemTimeout rises after 4 wait cycles and stays 1. Only rst_n low clears it.
- Saturation/reset: CNT_WIDTH=4, force 20 stall cycles → StallCount=15. Pulse rst_n low mid-WAIT → counters=0, FSM IDLE immediately.
